// File: rtl/alu_pkg.sv
// Shared ALU decoder codes, datapath width and mul/div FSM states.
// Imported by the ALU-side datapath blocks.
package alu_pkg;

    localparam int XLEN = 32;

    localparam logic [5:0] ALU_ADD  = 6'b100000;
    localparam logic [5:0] ALU_SUB  = 6'b100010;
    localparam logic [5:0] ALU_AND  = 6'b100100;
    localparam logic [5:0] ALU_OR   = 6'b100101;
    localparam logic [5:0] ALU_SLT  = 6'b101010;
    localparam logic [5:0] ALU_MULT = 6'b110001;
    localparam logic [5:0] ALU_MFLO = 6'b110010;
    localparam logic [5:0] ALU_MFHI = 6'b110011;
    localparam logic [5:0] ALU_DIV  = 6'b110100;

    typedef enum logic [1:0] {
        MD_IDLE,
        MD_RUN,
        MD_FIX
    } md_state_t;

endpackage

// File: rtl/muldiv_step.sv
// One radix-2 iteration on magnitudes: shift-add multiply or
// restoring subtract-shift divide over the {acc, lo} pair.
module muldiv_step
    import alu_pkg::*;
#(
    parameter int WIDTH = XLEN
) (
    input  logic             is_div,
    input  logic [WIDTH-1:0] acc,
    input  logic [WIDTH-1:0] lo,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] acc_n,
    output logic [WIDTH-1:0] lo_n
);

    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   shl;
    logic [WIDTH+1:0] diff;

    always_comb begin
        sum  = {1'b0, acc} + {1'b0, (lo[0] ? b : '0)};
        shl  = {acc, lo[WIDTH-1]};
        diff = {1'b0, shl} - {2'b00, b};
        if (is_div) begin
            // a borrow out of the trial subtract means the quotient bit is 0
            acc_n = diff[WIDTH+1] ? shl[WIDTH-1:0] : diff[WIDTH-1:0];
            lo_n  = {lo[WIDTH-2:0], ~diff[WIDTH+1]};
        end else begin
            acc_n = sum[WIDTH:1];
            lo_n  = {sum[0], lo[WIDTH-1:1]};
        end
    end

endmodule

// File: rtl/muldiv_hilo.sv
// Multi-cycle signed MULT/DIV with architectural HI/LO registers
// and a core stall for in-flight operations and early HI/LO reads.
module muldiv_hilo
    import alu_pkg::*;
#(
    parameter int WIDTH = XLEN
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [5:0]       alucontrol,
    input  logic [WIDTH-1:0] srca,
    input  logic [WIDTH-1:0] srcb,
    output logic [WIDTH-1:0] hilo_rd,
    output logic             busy,
    output logic             done,
    output logic             stall
);

    localparam int CW = $clog2(WIDTH);

    md_state_t          state;
    logic [CW-1:0]      cnt;
    logic [WIDTH-1:0]   hi, lo;
    logic [WIDTH-1:0]   acc, q, b;
    logic               is_div, qneg, rneg;
    logic [WIDTH-1:0]   acc_n, q_n;
    logic [WIDTH-1:0]   mag_a, mag_b;
    logic [2*WIDTH-1:0] prod;
    logic               md_op, rd_op, op_div;

    assign op_div = (alucontrol == ALU_DIV);
    assign md_op  = (alucontrol == ALU_MULT) | op_div;
    assign rd_op  = (alucontrol == ALU_MFHI) | (alucontrol == ALU_MFLO);
    assign stall  = busy & (md_op | rd_op);

    assign mag_a = srca[WIDTH-1] ? -srca : srca;
    assign mag_b = srcb[WIDTH-1] ? -srcb : srcb;
    assign prod  = qneg ? -{acc, q} : {acc, q};

    always_comb begin
        hilo_rd = '0;
        if (alucontrol == ALU_MFHI) hilo_rd = hi;
        if (alucontrol == ALU_MFLO) hilo_rd = lo;
    end

    muldiv_step #(.WIDTH(WIDTH)) u_step (
        .is_div (is_div),
        .acc    (acc),
        .lo     (q),
        .b      (b),
        .acc_n  (acc_n),
        .lo_n   (q_n)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= MD_IDLE;
            cnt    <= '0;
            hi     <= '0;
            lo     <= '0;
            acc    <= '0;
            q      <= '0;
            b      <= '0;
            is_div <= 1'b0;
            qneg   <= 1'b0;
            rneg   <= 1'b0;
            busy   <= 1'b0;
            done   <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                MD_IDLE: begin
                    if (start && md_op) begin
                        state  <= MD_RUN;
                        busy   <= 1'b1;
                        cnt    <= '0;
                        is_div <= op_div;
                        acc    <= '0;
                        q      <= mag_a;
                        b      <= mag_b;
                        // x/0 keeps an unsigned all-ones quotient
                        qneg   <= (srca[WIDTH-1] ^ srcb[WIDTH-1]) &
                                  ~(op_div && srcb == '0);
                        rneg   <= srca[WIDTH-1];
                    end
                end
                MD_RUN: begin
                    acc <= acc_n;
                    q   <= q_n;
                    cnt <= cnt + 1'b1;
                    if (cnt == CW'(WIDTH - 1)) state <= MD_FIX;
                end
                MD_FIX: begin
                    if (is_div) begin
                        lo <= qneg ? -q : q;
                        hi <= rneg ? -acc : acc;
                    end else begin
                        {hi, lo} <= prod;
                    end
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= MD_IDLE;
                end
                default: state <= MD_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_hilo.sv
// Randomised bench for muldiv_hilo against an arithmetic
// reference model of signed MULT/DIV and HI/LO behaviour.
module tb_muldiv_hilo;
    import alu_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [5:0]  alucontrol;
    logic [31:0] srca, srcb;
    logic [31:0] hilo_rd;
    logic        busy, done, stall;

    int n_chk = 0;
    int n_fail = 0;

    logic [31:0] hi_m, lo_m;

    always #5 clk = ~clk;

    muldiv_hilo #(.WIDTH(32)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .alucontrol (alucontrol),
        .srca       (srca),
        .srcb       (srcb),
        .hilo_rd    (hilo_rd),
        .busy       (busy),
        .done       (done),
        .stall      (stall)
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic model(input logic [5:0] op, input logic [31:0] a,
                         input logic [31:0] bb);
        longint p;
        int ai, bi;
        ai = $signed(a);
        bi = $signed(bb);
        if (op == ALU_MULT) begin
            p = longint'(ai) * longint'(bi);
            hi_m = p[63:32];
            lo_m = p[31:0];
        end else if (bi == 0) begin
            lo_m = 32'hFFFF_FFFF;
            hi_m = a;
        end else if (ai == 32'sh8000_0000 && bi == -1) begin
            lo_m = 32'h8000_0000;
            hi_m = 32'h0;
        end else begin
            lo_m = ai / bi;
            hi_m = ai % bi;
        end
    endtask

    // Called at a negedge; returns at the negedge of the done cycle.
    task automatic run_op(input logic [5:0] op, input logic [31:0] a,
                          input logic [31:0] bb);
        model(op, a, bb);
        start = 1'b1;
        alucontrol = op;
        srca = a;
        srcb = bb;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        alucontrol = ALU_MFHI;
        check("busy_after_e0", {31'b0, busy}, 32'd1);
        check("done_after_e0", {31'b0, done}, 32'd0);
        for (int k = 1; k <= 33; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (k == 5) begin
                alucontrol = ALU_ADD;
                #1 check("stall_unrelated", {31'b0, stall}, 32'd0);
                start = 1'b1;
                alucontrol = ALU_MULT;
                srca = ~a;
                srcb = a;
                #1 check("stall_md_busy", {31'b0, stall}, 32'd1);
            end else if (k == 6) begin
                start = 1'b0;
                alucontrol = ALU_MFHI;
            end
            if (k == 32) begin
                check("stall_e32", {31'b0, stall}, 32'd1);
                check("done_e32", {31'b0, done}, 32'd0);
            end
        end
        check("done_e33", {31'b0, done}, 32'd1);
        check("busy_e33", {31'b0, busy}, 32'd0);
        check("stall_e33", {31'b0, stall}, 32'd0);
        check("mfhi", hilo_rd, hi_m);
        alucontrol = ALU_MFLO;
        #1 check("mflo", hilo_rd, lo_m);
    endtask

    int dones;
    logic [5:0]  rop;
    logic [31:0] ra, rb;

    initial begin
        reset = 1'b1;
        start = 1'b0;
        alucontrol = ALU_MFLO;
        srca = '0;
        srcb = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("rst_mflo", hilo_rd, 32'h0);
        check("rst_stall", {31'b0, stall}, 32'd0);
        check("rst_busy", {31'b0, busy}, 32'd0);
        check("rst_done", {31'b0, done}, 32'd0);

        run_op(ALU_MULT, 32'd7, -32'sd3);
        run_op(ALU_MULT, 32'h8000_0000, 32'h8000_0000);
        run_op(ALU_DIV, -32'sd7, 32'd2);
        run_op(ALU_DIV, 32'd5, 32'd0);
        run_op(ALU_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
        @(negedge clk);
        check("done_drop", {31'b0, done}, 32'd0);

        for (int i = 0; i < 20; i++) begin
            rop = ($urandom_range(0, 1) == 0) ? ALU_MULT : ALU_DIV;
            ra = $urandom;
            rb = $urandom;
            if ($urandom_range(0, 3) == 0) rb = $urandom_range(0, 9) - 5;
            if ($urandom_range(0, 7) == 0) rb = 32'h0;
            run_op(rop, ra, rb);
            if (i % 2 == 1) @(negedge clk);
        end

        // abort a DIV at E10 with reset
        start = 1'b1;
        alucontrol = ALU_DIV;
        srca = 32'd1000;
        srcb = 32'd7;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        alucontrol = ALU_MFHI;
        repeat (10) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("abort_busy", {31'b0, busy}, 32'd0);
        check("abort_done", {31'b0, done}, 32'd0);
        check("abort_hi", hilo_rd, 32'h0);
        alucontrol = ALU_MFLO;
        #1 check("abort_lo", hilo_rd, 32'h0);
        @(negedge clk);
        reset = 1'b0;
        dones = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (done) dones++;
        end
        check("abort_no_done", dones, 32'd0);
        check("abort_lo_kept", hilo_rd, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
